// File: rtl/mem_bus_ctrl_if.sv
// CPU-side, RAM-side and I/O-side signals of the memory-bus controller.
// The slave modport is the controller's view; master is the cpu/RAM/I/O side.
interface mem_bus_ctrl_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RAM_AW = 8,
    parameter int unsigned NUM_IO = 2
);
    logic [1:0]               mem_cmd;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        write_data;
    logic [DATA_W-1:0]        read_data;
    logic                     mem_ready;
    logic                     bus_err;
    logic [7:0]               err_count;
    logic [RAM_AW-1:0]        ram_addr;
    logic                     ram_write;
    logic [DATA_W-1:0]        ram_din;
    logic [DATA_W-1:0]        ram_dout;
    logic [NUM_IO-1:0]        io_wr_en;
    logic [DATA_W-1:0]        io_wr_data;
    logic [NUM_IO*DATA_W-1:0] io_rd_data;

    modport slave (
        input  mem_cmd, mem_addr, write_data, ram_dout, io_rd_data,
        output read_data, mem_ready, bus_err, err_count,
               ram_addr, ram_write, ram_din, io_wr_en, io_wr_data
    );

    modport master (
        output mem_cmd, mem_addr, write_data, ram_dout, io_rd_data,
        input  read_data, mem_ready, bus_err, err_count,
               ram_addr, ram_write, ram_din, io_wr_en, io_wr_data
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: decodes cpu accesses into RAM / I/O slots, flags
// unmapped or illegal accesses, and returns a registered read_data with mem_ready.
module mem_bus_ctrl #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RAM_AW = 8,
    parameter int unsigned NUM_IO = 2,
    parameter int unsigned RD_LAT = 1
) (
    input logic           clk,
    input logic           reset,
    mem_bus_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = ADDR_W - 1;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_ILL   = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        DONE
    } state_t;

    state_t              state_q;
    logic [2:0]          cnt_q;
    logic [DATA_W-1:0]   read_data_q;
    logic                mem_ready_q;
    logic                bus_err_q;
    logic [7:0]          err_count_q;
    logic [RAM_AW-1:0]   ram_addr_q;
    logic                ram_write_q;
    logic [DATA_W-1:0]   ram_din_q;
    logic [NUM_IO-1:0]   io_wr_en_q;
    logic [DATA_W-1:0]   io_wr_data_q;

    logic                is_io_d;
    logic [IDX_W-1:0]    io_idx_d;
    logic                io_hit_d;
    logic                cmd_rd_d;
    logic                cmd_wr_d;
    logic                acc_err_d;
    logic [DATA_W-1:0]   io_sel_d;
    logic [NUM_IO-1:0]   io_onehot_d;

    always_comb begin
        is_io_d     = bus.mem_addr[ADDR_W-1];
        io_idx_d    = bus.mem_addr[ADDR_W-2:0];
        io_hit_d    = is_io_d && (io_idx_d < IDX_W'(NUM_IO));
        cmd_rd_d    = (bus.mem_cmd == CMD_READ);
        cmd_wr_d    = (bus.mem_cmd == CMD_WRITE);
        acc_err_d   = (bus.mem_cmd == CMD_ILL) || (is_io_d && !io_hit_d);
        io_sel_d    = '0;
        io_onehot_d = '0;
        for (int unsigned i = 0; i < NUM_IO; i++) begin
            if (io_idx_d == IDX_W'(i)) begin
                io_sel_d       = bus.io_rd_data[i*DATA_W +: DATA_W];
                io_onehot_d[i] = 1'b1;
            end
        end
    end

    // DONE holds for the mem_ready cycle so the still-held command is not re-accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            read_data_q  <= '0;
            mem_ready_q  <= 1'b0;
            bus_err_q    <= 1'b0;
            err_count_q  <= '0;
            ram_addr_q   <= '0;
            ram_write_q  <= 1'b0;
            ram_din_q    <= '0;
            io_wr_en_q   <= '0;
            io_wr_data_q <= '0;
        end else begin
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
            ram_write_q <= 1'b0;
            io_wr_en_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.mem_cmd != CMD_NONE) begin
                        state_q <= DONE;
                        if (acc_err_d) begin
                            mem_ready_q <= 1'b1;
                            bus_err_q   <= 1'b1;
                            if (cmd_rd_d) read_data_q <= '0;
                            if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
                        end else if (is_io_d) begin
                            mem_ready_q <= 1'b1;
                            if (cmd_wr_d) begin
                                io_wr_en_q   <= io_onehot_d;
                                io_wr_data_q <= bus.write_data;
                            end else begin
                                read_data_q  <= io_sel_d;
                            end
                        end else begin
                            ram_addr_q <= bus.mem_addr[RAM_AW-1:0];
                            if (cmd_wr_d) begin
                                ram_write_q <= 1'b1;
                                ram_din_q   <= bus.write_data;
                                mem_ready_q <= 1'b1;
                            end else begin
                                state_q <= RD_WAIT;
                                cnt_q   <= 3'(RD_LAT);
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 3'd1) begin
                        read_data_q <= bus.ram_dout;
                        mem_ready_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.read_data  = read_data_q;
    assign bus.mem_ready  = mem_ready_q;
    assign bus.bus_err    = bus_err_q;
    assign bus.err_count  = err_count_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_write  = ram_write_q;
    assign bus.ram_din    = ram_din_q;
    assign bus.io_wr_en   = io_wr_en_q;
    assign bus.io_wr_data = io_wr_data_q;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: instance A (RD_LAT=1) for function and
// error counting, instance B (RD_LAT=3) for read latency and mid-read reset.
module tb_mem_bus_ctrl;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        logic [15:0] rd;
        logic        err;
        int          lat;
        int          issue;
        int          nrw;
        logic [1:0]  ioen;
        logic [7:0]  ra;
        logic [7:0]  errc;
        logic        chk_din;
        logic        chk_iow;
        logic [15:0] wd;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    mem_bus_ctrl_if #(.ADDR_W(9), .DATA_W(16), .RAM_AW(8), .NUM_IO(2)) bus_a ();
    mem_bus_ctrl_if #(.ADDR_W(9), .DATA_W(16), .RAM_AW(8), .NUM_IO(2)) bus_b ();

    mem_bus_ctrl #(.ADDR_W(9), .DATA_W(16), .RAM_AW(8), .NUM_IO(2), .RD_LAT(1)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a)
    );
    mem_bus_ctrl #(.ADDR_W(9), .DATA_W(16), .RAM_AW(8), .NUM_IO(2), .RD_LAT(3)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b)
    );

    // RAM for A: combinational read of the registered ram_addr gives 1-cycle latency.
    logic [15:0] mem_a [256];
    always @(posedge clk) if (bus_a.ram_write) mem_a[bus_a.ram_addr] <= bus_a.ram_din;
    assign bus_a.ram_dout   = mem_a[bus_a.ram_addr];
    assign bus_a.io_rd_data = {16'h5678, 16'h1234};

    // B's RAM data changes every cycle, so only the last-cycle sample matches.
    assign bus_b.ram_dout   = 16'(32'hB000 + cyc);
    assign bus_b.io_rd_data = {16'h2222, 16'h1111};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endfunction

    function automatic void check_resp(input string t, input exp_t e, input logic [15:0] rd,
                                       input logic err, input int lat, input int nrw, input int nio,
                                       input logic [1:0] ior, input logic [7:0] ra,
                                       input logic [7:0] errc, input logic [15:0] din,
                                       input logic [15:0] iowd, input logic bad);
        cmp({t, ".read_data"},   32'(rd),   32'(e.rd));
        cmp({t, ".bus_err"},     32'(err),  32'(e.err));
        cmp({t, ".latency"},     32'(lat),  32'(e.lat));
        cmp({t, ".ram_write_n"}, 32'(nrw),  32'(e.nrw));
        cmp({t, ".io_wr_en"},    32'(ior),  32'(e.ioen));
        cmp({t, ".io_wr_n"},     32'(nio),  (e.ioen != 2'b00) ? 32'd1 : 32'd0);
        cmp({t, ".ram_addr"},    32'(ra),   32'(e.ra));
        cmp({t, ".err_count"},   32'(errc), 32'(e.errc));
        cmp({t, ".overlap"},     32'(bad),  32'd0);
        if (e.chk_din) cmp({t, ".ram_din"},    32'(din),  32'(e.wd));
        if (e.chk_iow) cmp({t, ".io_wr_data"}, 32'(iowd), 32'(e.wd));
    endfunction

    initial begin : mon_a
        int nrw = 0, nio = 0;
        logic [1:0] ior = '0;
        logic bad = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_a.ram_write) nrw++;
            if (bus_a.io_wr_en != 2'b00) nio++;
            ior = ior | bus_a.io_wr_en;
            if ((bus_a.ram_write && bus_a.io_wr_en != 2'b00) || (bus_a.bus_err && !bus_a.mem_ready))
                bad = 1'b1;
            if (bus_a.mem_ready) begin
                if (q_a.size() == 0) begin
                    cmp("A.spurious_ready", 32'(bus_a.mem_ready), 32'd0);
                end else begin
                    e = q_a.pop_front();
                    check_resp("A", e, bus_a.read_data, bus_a.bus_err, cyc - e.issue, nrw, nio, ior,
                               bus_a.ram_addr, bus_a.err_count, bus_a.ram_din, bus_a.io_wr_data, bad);
                end
                nrw = 0; nio = 0; ior = '0; bad = 1'b0;
            end
        end
    end

    initial begin : mon_b
        int nrw = 0, nio = 0;
        logic [1:0] ior = '0;
        logic bad = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_b.ram_write) nrw++;
            if (bus_b.io_wr_en != 2'b00) nio++;
            ior = ior | bus_b.io_wr_en;
            if ((bus_b.ram_write && bus_b.io_wr_en != 2'b00) || (bus_b.bus_err && !bus_b.mem_ready))
                bad = 1'b1;
            if (bus_b.mem_ready) begin
                if (q_b.size() == 0) begin
                    cmp("B.spurious_ready", 32'(bus_b.mem_ready), 32'd0);
                end else begin
                    e = q_b.pop_front();
                    check_resp("B", e, bus_b.read_data, bus_b.bus_err, cyc - e.issue, nrw, nio, ior,
                               bus_b.ram_addr, bus_b.err_count, bus_b.ram_din, bus_b.io_wr_data, bad);
                end
                nrw = 0; nio = 0; ior = '0; bad = 1'b0;
            end
        end
    end

    task automatic wait_ready_a();
        logic got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            got = bus_a.mem_ready;
        end
        cmp("A.ready_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_ready_b();
        logic got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            got = bus_b.mem_ready;
        end
        cmp("B.ready_seen", 32'(got), 32'd1);
    endtask

    task automatic issue_a(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                           input logic [15:0] rd, input logic err, input int lat, input int nrw,
                           input logic [1:0] ioen, input logic [7:0] ra, input logic [7:0] errc,
                           input logic chk_din, input logic chk_iow);
        exp_t e;
        @(posedge clk); #1;
        bus_a.mem_cmd    = cmd;
        bus_a.mem_addr   = addr;
        bus_a.write_data = wd;
        e = '{rd: rd, err: err, lat: lat, issue: cyc, nrw: nrw, ioen: ioen, ra: ra,
              errc: errc, chk_din: chk_din, chk_iow: chk_iow, wd: wd};
        q_a.push_back(e);
        wait_ready_a();
        @(posedge clk); #1;
        bus_a.mem_cmd = 2'b00;
    endtask

    // Accept one edge after issue, ram_dout sampled RD_LAT=3 edges later: value issue+3.
    task automatic read_b(input logic [8:0] addr);
        exp_t e;
        @(posedge clk); #1;
        bus_b.mem_cmd    = 2'b01;
        bus_b.mem_addr   = addr;
        bus_b.write_data = '0;
        e = '{rd: 16'(32'hB000 + cyc + 3), err: 1'b0, lat: 4, issue: cyc, nrw: 0, ioen: 2'b00,
              ra: addr[7:0], errc: 8'd0, chk_din: 1'b0, chk_iow: 1'b0, wd: 16'h0000};
        q_b.push_back(e);
        wait_ready_b();
        @(posedge clk); #1;
        bus_b.mem_cmd = 2'b00;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ec;
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.mem_cmd = 2'b00; bus_a.mem_addr = '0; bus_a.write_data = '0;
        bus_b.mem_cmd = 2'b00; bus_b.mem_addr = '0; bus_b.write_data = '0;
        #1 rst_a = 1'b0; rst_b = 1'b0;
        #2;
        cmp("A.rst.read_data", 32'(bus_a.read_data), 32'd0);
        cmp("A.rst.mem_ready", 32'(bus_a.mem_ready), 32'd0);
        cmp("A.rst.bus_err",   32'(bus_a.bus_err),   32'd0);
        cmp("A.rst.err_count", 32'(bus_a.err_count), 32'd0);
        cmp("A.rst.ram_write", 32'(bus_a.ram_write), 32'd0);
        cmp("A.rst.io_wr_en",  32'(bus_a.io_wr_en),  32'd0);
        cmp("A.rst.ram_addr",  32'(bus_a.ram_addr),  32'd0);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;

        //       cmd    addr    wdata     rd        err lat nrw ioen   ra     errc din iow
        issue_a(2'b10, 9'h005, 16'hABCD, 16'h0000, 0,  1,  1, 2'b00, 8'h05, 8'd0, 1, 0);
        issue_a(2'b01, 9'h005, 16'h0000, 16'hABCD, 0,  2,  0, 2'b00, 8'h05, 8'd0, 0, 0);
        issue_a(2'b10, 9'h101, 16'h0042, 16'hABCD, 0,  1,  0, 2'b10, 8'h05, 8'd0, 0, 1);
        issue_a(2'b01, 9'h100, 16'h0000, 16'h1234, 0,  1,  0, 2'b00, 8'h05, 8'd0, 0, 0);
        issue_a(2'b01, 9'h101, 16'h0000, 16'h5678, 0,  1,  0, 2'b00, 8'h05, 8'd0, 0, 0);
        issue_a(2'b10, 9'h0AA, 16'h1357, 16'h5678, 0,  1,  1, 2'b00, 8'hAA, 8'd0, 1, 0);
        issue_a(2'b10, 9'h100, 16'h0077, 16'h5678, 0,  1,  0, 2'b01, 8'hAA, 8'd0, 0, 1);
        issue_a(2'b01, 9'h0AA, 16'h0000, 16'h1357, 0,  2,  0, 2'b00, 8'hAA, 8'd0, 0, 0);
        issue_a(2'b01, 9'h1F0, 16'h0000, 16'h0000, 1,  1,  0, 2'b00, 8'hAA, 8'd1, 0, 0);
        issue_a(2'b11, 9'h000, 16'hFFFF, 16'h0000, 1,  1,  0, 2'b00, 8'hAA, 8'd2, 0, 0);
        issue_a(2'b10, 9'h102, 16'h9999, 16'h0000, 1,  1,  0, 2'b00, 8'hAA, 8'd3, 0, 0);
        issue_a(2'b01, 9'h005, 16'h0000, 16'hABCD, 0,  2,  0, 2'b00, 8'h05, 8'd3, 0, 0);

        for (int i = 0; i < 300; i++) begin
            ec = (4 + i > 255) ? 255 : 4 + i;
            issue_a(2'b01, 9'h1F0, 16'h0000, 16'h0000, 1, 1, 0, 2'b00, 8'h05, 8'(ec), 0, 0);
        end
        issue_a(2'b01, 9'h005, 16'h0000, 16'hABCD, 0, 2, 0, 2'b00, 8'h05, 8'd255, 0, 0);

        read_b(9'h0FF);

        @(posedge clk); #1;
        bus_b.mem_cmd  = 2'b01;
        bus_b.mem_addr = 9'h010;
        @(posedge clk);
        @(posedge clk);
        #3 rst_b = 1'b0;
        #1;
        cmp("B.rst.read_data", 32'(bus_b.read_data), 32'd0);
        cmp("B.rst.mem_ready", 32'(bus_b.mem_ready), 32'd0);
        cmp("B.rst.bus_err",   32'(bus_b.bus_err),   32'd0);
        cmp("B.rst.ram_addr",  32'(bus_b.ram_addr),  32'd0);
        cmp("B.rst.ram_write", 32'(bus_b.ram_write), 32'd0);
        cmp("B.rst.err_count", 32'(bus_b.err_count), 32'd0);
        bus_b.mem_cmd = 2'b00;
        @(negedge clk);
        rst_b = 1'b1;
        repeat (8) @(negedge clk);
        cmp("B.post_rst.read_data", 32'(bus_b.read_data), 32'd0);
        read_b(9'h033);

        repeat (4) @(negedge clk);
        cmp("A.queue_drained", 32'(q_a.size()), 32'd0);
        cmp("B.queue_drained", 32'(q_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
